vend_dispenser: RTL

- Downstream stage of the vending FSM.
- Consumes the one-cycle vend strobe `out` and the 2-bit change code `charge`.
- Sequences the product-release motor, then the ten-unit coin ejector once per change coin.
- Reports busy, done, overrun and fault status to the panel/status logic.

---
 rtl/vend_pkg.sv | 44 ++++
 rtl/vend_dispenser_if.sv | 30 +++
 rtl/vend_dispenser_pulse_timer.sv | 36 +++
 rtl/vend_dispenser.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// -----------------------------------------------------------------------------
// vend_pkg: shared definitions for the vending dispenser slice.
//   - charge code constants (shared with the vending FSM and its bench)
//   - dispenser state encoding
//   - helpers: charge decode, illegal-code detect, integer max
// -----------------------------------------------------------------------------
package vend_pkg;

  localparam logic [1:0] CHG_NONE    = 2'b00;
  localparam logic [1:0] CHG_ONE     = 2'b01;
  localparam logic [1:0] CHG_ILLEGAL = 2'b10;
  localparam logic [1:0] CHG_TWO     = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_VEND      = 3'd1,
    ST_GAP       = 3'd2,
    ST_EJECT     = 3'd3,
    ST_EGAP      = 3'd4,
    ST_WAIT_DROP = 3'd5,
    ST_DONE      = 3'd6
  } state_t;

  // Number of ten-unit coins owed for a charge code; the illegal code owes none.
  function automatic logic [1:0] coins_for_charge(input logic [1:0] chg);
    logic [1:0] n;
    case (chg)
      CHG_NONE: n = 2'd0;
      CHG_ONE:  n = 2'd1;
      CHG_TWO:  n = 2'd2;
      default:  n = 2'd0;
    endcase
    return n;
  endfunction

  function automatic logic charge_is_illegal(input logic [1:0] chg);
    return (chg == CHG_ILLEGAL);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vend_dispenser_if.sv
// -----------------------------------------------------------------------------
// vend_dispenser_if: bundle between the vending FSM side (master) and the
// dispenser (slave).
//   master drives : out, charge, drop_sense, clr_status
//   slave drives  : product_motor, coin_eject, busy, done, overrun, fault
// -----------------------------------------------------------------------------
interface vend_dispenser_if #(
  parameter int CHARGE_WIDTH = 2
);
  logic                    out;
  logic [CHARGE_WIDTH-1:0] charge;
  logic                    drop_sense;
  logic                    clr_status;
  logic                    product_motor;
  logic                    coin_eject;
  logic                    busy;
  logic                    done;
  logic                    overrun;
  logic                    fault;

  modport master (
    output out, charge, drop_sense, clr_status,
    input  product_motor, coin_eject, busy, done, overrun, fault
  );

  modport slave (
    input  out, charge, drop_sense, clr_status,
    output product_motor, coin_eject, busy, done, overrun, fault
  );
endinterface

// File: rtl/vend_dispenser_pulse_timer.sv
// -----------------------------------------------------------------------------
// pulse_timer: loadable down-counter with a zero flag. Holds at zero (never
// wraps). Shared by every timed state of the dispenser.
//   clk, rst_n : clock, async active-low reset
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : value loaded; a state lasting N cycles loads N-1
//   zero       : count is zero (last cycle of the timed state)
// -----------------------------------------------------------------------------
module pulse_timer #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] count_r;

  // Down-counter: load, else decrement until zero, then hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {WIDTH{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (count_r != {WIDTH{1'b0}}) begin
      count_r <= count_r - WIDTH'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/vend_dispenser.sv
// -----------------------------------------------------------------------------
// vend_dispenser: downstream stage of the vending FSM. On an accepted vend
// strobe it runs the product motor, then pulses the coin ejector once per
// change coin, waits for the product-drop sensor and reports completion.
//   clk, rst_n : clock, async active-low reset
//   bus.slave  : out/charge/drop_sense/clr_status in;
//                product_motor/coin_eject/busy/done/overrun/fault out
//                (all outputs registered)
// -----------------------------------------------------------------------------
module vend_dispenser
  import vend_pkg::*;
#(
  parameter int CHARGE_WIDTH = 2,
  parameter int VEND_CYCLES  = 16,
  parameter int EJECT_CYCLES = 8,
  parameter int GAP_CYCLES   = 4,
  parameter int DROP_TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  vend_dispenser_if.slave bus
);

  localparam int MAX_CYC = max_int(max_int(VEND_CYCLES, EJECT_CYCLES),
                                   max_int(GAP_CYCLES, DROP_TIMEOUT));
  localparam int TIMER_W = $clog2(MAX_CYC) + 1;

  // The drop timeout runs from motor-off, but the shared timer is busy with
  // gaps/ejects until WAIT_DROP. The time already spent after motor-off is
  // fixed by the coin count, so WAIT_DROP loads only the remaining budget.
  localparam int COIN_SLOT   = GAP_CYCLES + EJECT_CYCLES;
  localparam int DROP_LOAD_0 = DROP_TIMEOUT - 1;
  localparam int DROP_LOAD_1 = DROP_TIMEOUT - 1 - COIN_SLOT;
  localparam int DROP_LOAD_2 = DROP_TIMEOUT - 1 - 2 * COIN_SLOT;

  state_t               state_r, next_state_s;
  logic [1:0]           coins_left_r, coins_init_r;
  logic                 drop_seen_r;
  logic                 overrun_r, fault_r;
  logic                 product_motor_r, coin_eject_r, busy_r, done_r;
  logic                 product_motor_s, coin_eject_s, busy_s, done_s;
  logic                 timer_load_s, timer_zero_s;
  logic [TIMER_W-1:0]   timer_val_s, drop_budget_s;
  logic                 accept_s, drop_now_s, active_s, fault_set_s, overrun_set_s;

  assign accept_s   = (state_r == ST_IDLE) && bus.out;
  assign drop_now_s = drop_seen_r || bus.drop_sense;
  // Drop latching window: VEND start through WAIT_DROP.
  assign active_s   = (state_r != ST_IDLE) && (state_r != ST_DONE);

  pulse_timer #(.WIDTH(TIMER_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load_s),
    .load_val (timer_val_s),
    .zero     (timer_zero_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.out) next_state_s = ST_VEND;
        else         next_state_s = ST_IDLE;
      end
      ST_VEND: begin
        if (!timer_zero_s)            next_state_s = ST_VEND;
        else if (coins_left_r != 2'd0) next_state_s = ST_GAP;
        else                          next_state_s = ST_WAIT_DROP;
      end
      ST_GAP: begin
        if (timer_zero_s) next_state_s = ST_EJECT;
        else              next_state_s = ST_GAP;
      end
      ST_EJECT: begin
        if (!timer_zero_s)            next_state_s = ST_EJECT;
        else if (coins_left_r > 2'd1) next_state_s = ST_EGAP;
        else                          next_state_s = ST_WAIT_DROP;
      end
      ST_EGAP: begin
        if (timer_zero_s) next_state_s = ST_EJECT;
        else              next_state_s = ST_EGAP;
      end
      ST_WAIT_DROP: begin
        if (drop_now_s || timer_zero_s) next_state_s = ST_DONE;
        else                            next_state_s = ST_WAIT_DROP;
      end
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Remaining drop-timeout budget on WAIT_DROP entry.
  always_comb begin
    case (coins_init_r)
      2'd1:    drop_budget_s = TIMER_W'(DROP_LOAD_1);
      2'd2:    drop_budget_s = TIMER_W'(DROP_LOAD_2);
      default: drop_budget_s = TIMER_W'(DROP_LOAD_0);
    endcase
  end

  // Timer reload on every state entry, with the entered state's duration.
  always_comb begin
    timer_load_s = (next_state_s != state_r);
    case (next_state_s)
      ST_VEND:      timer_val_s = TIMER_W'(VEND_CYCLES - 1);
      ST_GAP:       timer_val_s = TIMER_W'(GAP_CYCLES - 1);
      ST_EGAP:      timer_val_s = TIMER_W'(GAP_CYCLES - 1);
      ST_EJECT:     timer_val_s = TIMER_W'(EJECT_CYCLES - 1);
      ST_WAIT_DROP: timer_val_s = drop_budget_s;
      default:      timer_val_s = {TIMER_W{1'b0}};
    endcase
  end

  // Output decode from the next state so the registered outputs line up
  // with the state they belong to.
  always_comb begin
    product_motor_s = (next_state_s == ST_VEND);
    coin_eject_s    = (next_state_s == ST_EJECT);
    busy_s          = (next_state_s != ST_IDLE);
    done_s          = (next_state_s == ST_DONE);
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product_motor_r <= 1'b0;
      coin_eject_r    <= 1'b0;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
    end else begin
      product_motor_r <= product_motor_s;
      coin_eject_r    <= coin_eject_s;
      busy_r          <= busy_s;
      done_r          <= done_s;
    end
  end

  // Coin bookkeeping: capture only on an accepted strobe, count down per eject.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coins_left_r <= 2'd0;
      coins_init_r <= 2'd0;
    end else if (accept_s) begin
      coins_left_r <= coins_for_charge(bus.charge[1:0]);
      coins_init_r <= coins_for_charge(bus.charge[1:0]);
    end else if ((state_r == ST_EJECT) && timer_zero_s) begin
      coins_left_r <= coins_left_r - 2'd1;
      coins_init_r <= coins_init_r;
    end else begin
      coins_left_r <= coins_left_r;
      coins_init_r <= coins_init_r;
    end
  end

  // Drop latch: cleared on accept so a stale drop never completes a new sale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_seen_r <= 1'b0;
    end else if (accept_s) begin
      drop_seen_r <= 1'b0;
    end else if (active_s && bus.drop_sense) begin
      drop_seen_r <= 1'b1;
    end else begin
      drop_seen_r <= drop_seen_r;
    end
  end

  assign overrun_set_s = bus.out && (state_r != ST_IDLE);
  assign fault_set_s   = (accept_s && charge_is_illegal(bus.charge[1:0])) ||
                         ((state_r == ST_WAIT_DROP) && timer_zero_s && !drop_now_s);

  // Sticky status; a set event in the same cycle as clr_status wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_r <= 1'b0;
      fault_r   <= 1'b0;
    end else begin
      if (overrun_set_s)       overrun_r <= 1'b1;
      else if (bus.clr_status) overrun_r <= 1'b0;
      else                     overrun_r <= overrun_r;
      if (fault_set_s)         fault_r   <= 1'b1;
      else if (bus.clr_status) fault_r   <= 1'b0;
      else                     fault_r   <= fault_r;
    end
  end

  assign bus.product_motor = product_motor_r;
  assign bus.coin_eject    = coin_eject_r;
  assign bus.busy          = busy_r;
  assign bus.done          = done_r;
  assign bus.overrun       = overrun_r;
  assign bus.fault         = fault_r;

endmodule
